// File: rtl/lif_pkg.sv
// Shared constants and event layout for the LIF spike logger.
// Optional drop counter is enabled with the LIF_LOG_DROP_CNT_EN macro.
package lif_pkg;

  localparam int LIF_TS_W_DEF  = 6;
  localparam int LIF_N_NEURONS = 2;

  localparam int EVT_TS_LSB   = 0;
  localparam int EVT_MASK_LSB = LIF_TS_W_DEF;

  typedef struct packed {
    logic [LIF_N_NEURONS-1:0] mask;
    logic [LIF_TS_W_DEF-1:0]  ts;
  } lif_evt_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lif_evt_fifo.sv
// Generic synchronous FIFO with occupancy count; acceptance policy lives in the parent.
module lif_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO may still take a write when the same edge frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lif_spike_logger.sv
// Timestamps dual-neuron spike cycles and buffers them for a valid/ready reader.
// Define LIF_LOG_DROP_CNT_EN to add the saturating drop_cnt output.
module lif_spike_logger
  import lif_pkg::*;
#(
  parameter int TS_W  = LIF_TS_W_DEF,
  parameter int DEPTH = 4,
  localparam int EW   = TS_W + LIF_N_NEURONS,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     clr,
  input  logic [LIF_N_NEURONS-1:0] spike_in,
  output logic [EW-1:0]            evt_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [LW-1:0]            level,
`ifdef LIF_LOG_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic                     overflow
);

  logic [TS_W-1:0] ts;
  logic            spike_ev;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            drop;
  logic [EW-1:0]   evt_word;

  // Handshake: the head event transfers on any edge where evt_valid && evt_ready;
  // evt_data holds while evt_valid is high and evt_ready is low.
  assign evt_valid = !fifo_empty;
  assign fifo_pop  = evt_valid && evt_ready;
  assign spike_ev  = ena && (spike_in != '0);
  assign accept    = spike_ev && (!fifo_full || fifo_pop);
  assign drop      = spike_ev && !accept;
  assign evt_word  = {spike_in, ts};

  lif_evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (accept),
    .pop   (fifo_pop),
    .din   (evt_word),
    .dout  (evt_data),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts       <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      ts       <= '0;
      overflow <= 1'b0;
    end else begin
      if (ena) ts <= ts + TS_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef LIF_LOG_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    drop_cnt <= '0;
    else if (clr)  drop_cnt <= '0;
    else if (drop) drop_cnt <= sat_inc8(drop_cnt);
  end
`endif

endmodule

// File: tb/tb_lif_spike_logger.sv
// Bench for lif_spike_logger: vector table, corner sequences and a queue scoreboard.
module tb_lif_spike_logger;
  import lif_pkg::*;

  localparam int TS_W  = 6;
  localparam int DEPTH = 4;
  localparam int W     = TS_W + 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          clr;
  logic [1:0]    spike_in;
  logic [W-1:0]  evt_data;
  logic          evt_valid;
  logic          evt_ready;
  logic [LW-1:0] level;
  logic          overflow;
`ifdef LIF_LOG_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  lif_spike_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr       (clr),
    .spike_in  (spike_in),
    .evt_data  (evt_data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .level     (level),
`ifdef LIF_LOG_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .overflow  (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0]    exp_q[$];
  logic [TS_W-1:0] m_ts  = '0;
  logic            m_ovf = 1'b0;
  logic [7:0]      m_drop = '0;

  typedef struct {
    logic          e;
    logic          c;
    logic [1:0]    s;
    logic          r;
    logic [LW-1:0] lvl;
    logic          vld;
    logic          ovf;
    logic [W-1:0]  dat;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, input logic c, input logic [1:0] s, input logic r,
                              input int lvl, input logic vld, input logic ovf, input logic [W-1:0] dat);
    vec_t v;
    v.e = e; v.c = c; v.s = s; v.r = r;
    v.lvl = LW'(lvl); v.vld = vld; v.ovf = ovf; v.dat = dat;
    return v;
  endfunction

  // One clock: drive at negedge, score pops before the edge, check state after it.
  task automatic step(input logic e, input logic c, input logic [1:0] s, input logic r);
    logic popped;
    @(negedge clk);
    ena = e; clr = c; spike_in = s; evt_ready = r;
    #1;
    popped = !c && evt_valid && r;
    if (popped) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_evt_data", 32'(evt_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
    if (c) begin
      exp_q.delete();
      m_ts = '0; m_ovf = 1'b0; m_drop = '0;
    end else begin
      if (e && s != 2'b00) begin
        if (exp_q.size() < DEPTH || popped) exp_q.push_back({s, m_ts});
        else begin
          m_ovf = 1'b1;
          if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
        end
      end
      if (e) m_ts = m_ts + TS_W'(1);
    end
    @(posedge clk);
    #1;
    chk("sb_level", 32'(level), 32'(exp_q.size()));
    chk("sb_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    chk("sb_overflow", 32'(overflow), 32'(m_ovf));
    if (exp_q.size() != 0) chk("sb_head", 32'(evt_data), 32'(exp_q[0]));
`ifdef LIF_LOG_DROP_CNT_EN
    chk("sb_drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; clr = 1'b0; spike_in = 2'b00; evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_data", 32'(evt_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic ordering, dual spike, overflow and full push+pop
    vecs[0]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    vecs[2]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 8'h00);
    vecs[3]  = mk(1, 0, 2'b01, 0, 1, 1, 0, 8'h43);
    vecs[4]  = mk(1, 0, 2'b00, 0, 1, 1, 0, 8'h43);
    vecs[5]  = mk(1, 0, 2'b10, 0, 2, 1, 0, 8'h43);
    vecs[6]  = mk(1, 0, 2'b00, 1, 1, 1, 0, 8'h85);
    vecs[7]  = mk(1, 0, 2'b11, 1, 1, 1, 0, 8'hC7);
    vecs[8]  = mk(1, 0, 2'b00, 0, 1, 1, 0, 8'hC7);
    vecs[9]  = mk(1, 0, 2'b00, 1, 0, 0, 0, 8'h00);
    vecs[10] = mk(1, 0, 2'b01, 0, 1, 1, 0, 8'h4A);
    vecs[11] = mk(1, 0, 2'b01, 0, 2, 1, 0, 8'h4A);
    vecs[12] = mk(1, 0, 2'b01, 0, 3, 1, 0, 8'h4A);
    vecs[13] = mk(1, 0, 2'b01, 0, 4, 1, 0, 8'h4A);
    vecs[14] = mk(1, 0, 2'b01, 0, 4, 1, 1, 8'h4A);
    vecs[15] = mk(1, 0, 2'b01, 0, 4, 1, 1, 8'h4A);
    vecs[16] = mk(1, 0, 2'b10, 1, 4, 1, 1, 8'h4B);
    vecs[17] = mk(1, 0, 2'b00, 1, 3, 1, 1, 8'h4C);
    vecs[18] = mk(1, 0, 2'b00, 1, 2, 1, 1, 8'h4D);
    vecs[19] = mk(1, 0, 2'b00, 1, 1, 1, 1, 8'h90);
    vecs[20] = mk(1, 0, 2'b00, 1, 0, 0, 1, 8'h00);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].e, vecs[i].c, vecs[i].s, vecs[i].r);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].vld));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
      if (vecs[i].vld) chk($sformatf("vec%0d_data", i), 32'(evt_data), 32'(vecs[i].dat));
    end
`ifdef LIF_LOG_DROP_CNT_EN
    chk("drop_cnt_two", 32'(drop_cnt), 32'd2);
`endif

    // Timestamp wrap 63 -> 0
    for (int i = 0; i < 64 && m_ts != 6'd63; i++) step(1, 0, 2'b00, 0);
    step(1, 0, 2'b01, 0);
    step(1, 0, 2'b10, 0);
    chk("wrap_level", 32'(level), 32'd2);
    chk("wrap_head_63", 32'(evt_data), 32'h7F);

    // ena low: timestamp frozen, spikes ignored, FIFO still drains
    step(0, 0, 2'b11, 1);
    chk("wrap_head_0", 32'(evt_data), 32'h80);
    for (int i = 0; i < 9; i++) step(0, 0, 2'($urandom_range(1, 3)), 1);
    chk("ena_off_drained", 32'(level), 32'd0);
    step(1, 0, 2'b01, 0);
    chk("ena_off_ts_frozen", 32'(evt_data), 32'h41);
    step(1, 0, 2'b00, 1);

    // clr with buffered events, a same-cycle spike and overflow set
    for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 0);
    chk("pre_clr_overflow", 32'(overflow), 32'd1);
    step(1, 1, 2'b11, 0);
    chk("clr_level", 32'(level), 32'd0);
    chk("clr_valid", 32'(evt_valid), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    step(1, 0, 2'b10, 0);
    chk("clr_ts_zero", 32'(evt_data), 32'h80);

    // Randomised traffic against the scoreboard
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 0, 2'b01, 0);
    @(negedge clk);
    ena = 1'b0; spike_in = 2'b00; evt_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_valid", 32'(evt_valid), 32'd0);
    chk("async_rst_data", 32'(evt_data), 32'd0);
    chk("async_rst_overflow", 32'(overflow), 32'd0);
`ifdef LIF_LOG_DROP_CNT_EN
    chk("async_rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    exp_q.delete();
    m_ts = '0; m_ovf = 1'b0; m_drop = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 2'b01, 0);
    chk("post_rst_ts_zero", 32'(evt_data), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_spike_logger.md
# lif_spike_logger

Downstream stage of the dual leaky integrate-and-fire neuron core. Captures the two neurons' spike pulses, tags each spiking cycle with a free-running timestamp, and buffers the events in a small FIFO. A valid/ready port drains the FIFO so spike trains can be read off-chip through the dedicated outputs. Overflow is flagged rather than stalling the neuron core.

## Interface
- `TS_W`, 6: timestamp width in bits; the event word is `TS_W+2` bits.
- `DEPTH`, 4: FIFO entries; power of two, 2..16.

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; low freezes the timestamp and ignores spikes.
- `clr` in 1: synchronous clear of the FIFO, timestamp, and flags.
- `spike_in` in 2: one-cycle spike pulses from the neuron core; bit0 is neuron 0, bit1 is neuron 1.
- `evt_data` out `TS_W+2`: head event, laid out as `{mask[1:0], ts[TS_W-1:0]}`.
- `evt_valid` out 1: FIFO is non-empty.
- `evt_ready` in 1: consumer accepts the head event.
- `level` out `$clog2(DEPTH)+1`: current occupancy.
- `overflow` out 1: sticky; an event was dropped.
- `drop_cnt` out 8: saturating count of dropped events. Present only with `LIF_LOG_DROP_CNT_EN`.

## Operation
- Timestamp `ts` increments by 1 each cycle while `ena=1`.
  - Wraps from `2^TS_W-1` to 0.
  - Holds its value while `ena=0`.
- Event generation: in any cycle with `ena=1` and `spike_in!=0`, one event `{spike_in, ts}` is pushed.
  - `ts` is the value before this cycle's increment.
  - Simultaneous spikes from both neurons produce one event with mask `2'b11`, not two events.
- Pop: occurs when `evt_valid && evt_ready`.
- Push acceptance: a push is accepted if `level<DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set.
  - With the macro defined, `drop_cnt` increments, saturating at 255.
- Simultaneous push and pop:
  - When not full, `level` is unchanged.
  - When full, the pop frees a slot and the push is accepted.
  - When empty, the push is accepted and nothing is popped, because `evt_valid` was 0.
- `evt_data` is held stable while `evt_valid=1 && evt_ready=0`.
- `clr` has priority over push, pop, and the timestamp increment. It forces `level=0`, `ts=0`, `overflow=0`, and `drop_cnt=0`, and the same-cycle spike is discarded.
- `ena=0` has no effect on the pop side; the FIFO keeps draining.
- Arithmetic rules:
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - `level` is computed with one extra bit so that full (`level==DEPTH`) is distinguishable from empty.
- Reset state: `level=0`, `evt_valid=0`, `evt_data=0`, `overflow=0`, `drop_cnt=0`, `ts=0`, pointers 0.
- Reset asserted mid-operation discards all buffered events immediately, asynchronously.

## Timing
- A spike at edge N (sampled at edge N) is pushed at edge N.
  - If the FIFO was empty, `evt_valid=1` and `evt_data` are valid after edge N, i.e. in cycle N+1.
  - Latency is therefore 1 cycle.
- A pop at edge M presents the next entry (or `evt_valid=0`) in cycle M+1.
  - Back-to-back pops at one per cycle are supported.
- `evt_data`, `evt_valid`, `level`, `overflow`, and `drop_cnt` are all registered; there is no combinational path from `spike_in` or `evt_ready` to any output.
- `overflow` rises in the cycle after the dropping edge.

## Configuration
- Macro: `LIF_LOG_DROP_CNT_EN`.
- Defined: the `drop_cnt` port and its 8-bit saturating counter exist, with clear and reset as described above.
- Undefined: the port and counter are absent; only the sticky `overflow` reports drops. All other behaviour is identical.

## Structure
- Package `lif_pkg` holds:
  - `LIF_TS_W_DEF`=6 and `LIF_N_NEURONS`=2;
  - localparams for the event field offsets (`EVT_MASK_LSB=TS_W`);
  - typedef `lif_evt_t` as a packed struct `{logic [1:0] mask; logic [TS_W-1:0] ts;}`, sized from the default.
- One sub-module, `lif_evt_fifo`, which is the generic synchronous FIFO.
  - Ports: push, pop, data in/out, level, full, empty.
  - It has no drop logic; the top level decides acceptance and owns `ts`, `overflow`, and `drop_cnt`.

## Test plan
- Reset, then spikes `2'b01` at ts=3 and `2'b10` at ts=5 with `evt_ready=0`: `level=2`, `evt_data`=`{01,3}`. Raise `evt_ready`: next output is `{10,5}`, then `evt_valid=0`.
- Spike `2'b11` at ts=7: exactly one event `{11,7}`, `level=1`.
- `evt_ready=0` with 6 spiking cycles at DEPTH=4: `level=4`, `overflow=1`, `drop_cnt=2` (macro defined). The first 4 timestamps are preserved in order.
- FIFO full, spike and `evt_ready=1` in the same cycle: no drop, `level` stays 4, and the new event becomes the tail.
- Run 64+ cycles: `ts` wraps 63→0, and the event after the wrap carries ts=0. Hold `ena=0` for 10 cycles: `ts` is frozen and spikes are ignored, while the FIFO still drains.
- `clr` with 3 buffered events, a same-cycle spike, and `overflow=1`: next cycle `level=0`, `evt_valid=0`, `overflow=0`, `ts=0`. Assert `rst_n=0` asynchronously mid-stream: outputs go to reset values before the next edge.
